// File: rtl/daq_frame_ctrl.sv
// DAQ line framer: header, payload, tailer into the host read FIFO. DAQ_CHECKSUM_EN puts a payload XOR in the tailer.
// Latency: a START edge moves IDLE to HDR at the next clock, and the header write follows in that cycle. Words are then written back to back.
// Backpressure: fifo_full freezes the state, the counters and fifo_din. A RESET command or fifo_open dropping aborts the line.
module daq_frame_ctrl #(
  parameter int          WORDS_PER_LINE  = 24,
  parameter int          LINES_PER_FRAME = 16,
  parameter logic [7:0]  CMD_START       = 8'hFF,
  parameter logic [7:0]  CMD_RESET       = 8'hC0,
  parameter logic [7:0]  CMD_CLOSE       = 8'hC7
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic [7:0]  cfg_byte,
  input  logic        fifo_open,
  input  logic        fifo_full,
  output logic [31:0] fifo_din,
  output logic        fifo_wr_en,
  output logic        daq_running,
  output logic        frame_done,
  output logic [15:0] line_idx,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, TAIL} state_t;

  localparam logic [7:0]  LAST_WORD = 8'(WORDS_PER_LINE - 1);
  localparam logic [15:0] LAST_LINE = 16'(LINES_PER_FRAME - 1);

  state_t      state, state_nxt;
  logic [7:0]  cfg_q;
  logic [31:0] pay_cnt;
  logic [7:0]  word_idx;
  logic        close_pending;
  logic        cfg_chg, cmd_start, cmd_reset, cmd_close;
  logic        running, abort, last_word, last_line, close_now;
  logic [23:0] tail_low24;

  // A command counts only when the host writes a new value into the register.
  assign cfg_chg   = (cfg_byte != cfg_q);
  assign cmd_start = cfg_chg && (cfg_byte == CMD_START);
  assign cmd_reset = cfg_chg && (cfg_byte == CMD_RESET);
  assign cmd_close = cfg_chg && (cfg_byte == CMD_CLOSE);

  assign running   = (state != IDLE);
  assign abort     = cmd_reset || (running && !fifo_open);
  assign last_word = (word_idx == LAST_WORD);
  assign last_line = (line_idx == LAST_LINE);
  assign close_now = close_pending || cmd_close;

  assign daq_running = running;

`ifdef DAQ_CHECKSUM_EN
  logic [23:0] csum;

  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n || abort || state == HDR) begin
      csum <= 24'h0;
    end else if (state == PAY && !fifo_full) begin
      csum <= csum ^ pay_cnt[23:0];
    end
  end

  assign tail_low24 = csum;
`else
  assign tail_low24 = {8'h00, line_idx};
`endif

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (cmd_start && fifo_open) state_nxt = HDR;
        HDR:  if (!fifo_full) state_nxt = PAY;
        PAY:  if (!fifo_full && last_word) state_nxt = TAIL;
        TAIL: if (!fifo_full) state_nxt = close_now ? IDLE : HDR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_din   = 32'h0;
    fifo_wr_en = running && !fifo_full;
    case (state)
      HDR:     fifo_din = {8'hF0, 8'h00, line_idx};
      PAY:     fifo_din = pay_cnt;
      TAIL:    fifo_din = {8'hAA, tail_low24};
      default: fifo_din = 32'h0;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      state         <= IDLE;
      cfg_q         <= cfg_byte;
      pay_cnt       <= 32'h0;
      word_idx      <= 8'h0;
      line_idx      <= 16'h0;
      frame_cnt     <= 16'h0;
      close_pending <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      cfg_q      <= cfg_byte;
      state      <= state_nxt;
      frame_done <= 1'b0;
      if (abort) begin
        pay_cnt       <= 32'h0;
        word_idx      <= 8'h0;
        line_idx      <= 16'h0;
        frame_cnt     <= 16'h0;
        close_pending <= 1'b0;
      end else begin
        if (running && cmd_close) close_pending <= 1'b1;
        case (state)
          IDLE: begin
            if (cmd_start && fifo_open) begin
              pay_cnt       <= 32'h0;
              word_idx      <= 8'h0;
              line_idx      <= 16'h0;
              frame_cnt     <= 16'h0;
              close_pending <= 1'b0;
            end
          end
          HDR: begin
            if (!fifo_full) word_idx <= 8'h0;
          end
          PAY: begin
            if (!fifo_full) begin
              pay_cnt  <= pay_cnt + 32'h1;
              word_idx <= word_idx + 8'h1;
            end
          end
          TAIL: begin
            if (!fifo_full) begin
              if (last_line) begin
                line_idx   <= 16'h0;
                frame_cnt  <= frame_cnt + 16'h1;
                frame_done <= 1'b1;
              end else begin
                line_idx <= line_idx + 16'h1;
              end
              // The line that carried the close has finished, so the request is consumed here.
              if (close_now) close_pending <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_daq_frame_ctrl.sv
// Directed bench for daq_frame_ctrl: framing, frame wrap, stall, close, reset and fifo_open abort.
module tb_daq_frame_ctrl;

  logic        bus_clk = 1'b0;
  logic        bus_rst_n;
  logic [7:0]  cfg_byte;
  logic        fifo_open;
  logic        fifo_full;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        daq_running;
  logic        frame_done;
  logic [15:0] line_idx;
  logic [15:0] frame_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] wq[$];
  int          wcount = 0;
  int          done_at[$];

  daq_frame_ctrl dut (
    .bus_clk    (bus_clk),
    .bus_rst_n  (bus_rst_n),
    .cfg_byte   (cfg_byte),
    .fifo_open  (fifo_open),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .daq_running(daq_running),
    .frame_done (frame_done),
    .line_idx   (line_idx),
    .frame_cnt  (frame_cnt)
  );

  always #5 bus_clk = ~bus_clk;

  // A write strobed at the falling edge lands in the FIFO on the following rising edge.
  always @(negedge bus_clk) begin
    if (frame_done) done_at.push_back(wcount);
    if (bus_rst_n === 1'b1 && fifo_wr_en === 1'b1) begin
      wq.push_back(fifo_din);
      wcount++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && wcount < n; i++) tick();
    chk("write_wait", 32'(wcount >= n), 32'd1);
  endtask

  function automatic logic [31:0] tail_exp(input int ln);
    logic [31:0] x;
    x = 32'h0;
`ifdef DAQ_CHECKSUM_EN
    for (int j = 0; j < 24; j++) x = x ^ 32'(ln * 24 + j);
    return {8'hAA, x[23:0]};
`else
    x = 32'(ln % 16);
    return {8'hAA, 8'h00, x[15:0]};
`endif
  endfunction

  // Line ln of the run starts at write 26*ln; payload values increase continuously across lines.
  function automatic logic [31:0] word_exp(input int k);
    int ln, pos;
    ln  = k / 26;
    pos = k % 26;
    if (pos == 0) return {8'hF0, 8'h00, 16'(ln % 16)};
    if (pos == 25) return tail_exp(ln);
    return 32'(ln * 24 + pos - 1);
  endfunction

  initial begin
    bus_rst_n = 1'b0;
    cfg_byte  = 8'h00;
    fifo_open = 1'b1;
    fifo_full = 1'b0;
    tick();
    tick();
    chk("rst_running", 32'(daq_running), 32'd0);
    chk("rst_wr_en",   32'(fifo_wr_en),  32'd0);
    chk("rst_din",     fifo_din,         32'h0);
    chk("rst_line",    32'(line_idx),    32'd0);
    chk("rst_frame",   32'(frame_cnt),   32'd0);
    chk("rst_done",    32'(frame_done),  32'd0);

    // An unknown code is ignored.
    bus_rst_n = 1'b1;
    cfg_byte  = 8'h55;
    tick();
    chk("unknown_idle", 32'(daq_running), 32'd0);

    // START: HDR right after the edge that sees 00->FF, header is driven in that cycle.
    cfg_byte = 8'hFF;
    #1;
    chk("pre_start_idle", 32'(daq_running), 32'd0);
    tick();
    chk("start_running", 32'(daq_running), 32'd1);
    chk("start_wr_en",   32'(fifo_wr_en),  32'd1);
    chk("start_hdr",     fifo_din,         32'hF000_0000);
    wait_writes(27, 100);
    chk("l0_hdr",  wq[0],  32'hF000_0000);
    chk("l0_p0",   wq[1],  32'h0000_0000);
    chk("l0_p23",  wq[24], 32'h0000_0017);
    chk("l0_tail", wq[25], 32'hAA00_0000);
    chk("l1_hdr",  wq[26], 32'hF000_0001);

    // A full frame of 16 lines is 416 writes; frame_done follows the last tailer.
    for (int i = 0; i < 600 && done_at.size() == 0; i++) tick();
    chk("done_seen",  32'(done_at.size()), 32'd1);
    chk("done_at",    32'(done_at[0]),     32'd416);
    chk("frame_cnt1", 32'(frame_cnt),      32'd1);
    chk("line_wrap",  32'(line_idx),       32'd0);

    // Stall in PAY: the next write is payload 0x183.
    wait_writes(420, 50);
    fifo_full = 1'b1;
    #1;
    chk("stall_wr_en0", 32'(fifo_wr_en), 32'd0);
    chk("stall_din0",   fifo_din,        32'h0000_0183);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("stall_din",   fifo_din,        32'h0000_0183);
    end
    chk("stall_count", 32'(wcount), 32'd420);
    fifo_full = 1'b0;

    // CLOSE with payload word 5 of line 17 pending: the line finishes, then IDLE.
    wait_writes(448, 100);
    cfg_byte = 8'hC7;
    for (int i = 0; i < 60 && daq_running; i++) tick();
    chk("close_idle",    32'(daq_running), 32'd0);
    chk("close_wr_en",   32'(fifo_wr_en),  32'd0);
    chk("close_din",     fifo_din,         32'h0);
    chk("close_wcount",  32'(wcount),      32'd468);
    chk("close_line",    32'(line_idx),    32'd2);
    chk("close_frame",   32'(frame_cnt),   32'd1);
    chk("close_ndone",   32'(done_at.size()), 32'd1);
    for (int k = 0; k < 468; k++) chk($sformatf("stream_w%0d", k), wq[k], word_exp(k));

    // Restart from C7 -> FF.
    cfg_byte = 8'hFF;
    tick();
    chk("restart_running", 32'(daq_running), 32'd1);
    chk("restart_hdr",     fifo_din,         32'hF000_0000);
    chk("restart_line",    32'(line_idx),    32'd0);
    chk("restart_frame",   32'(frame_cnt),   32'd0);
    tick();
    chk("restart_p0", fifo_din, 32'h0);

    // RESET with payload word 5 pending: IDLE at the next edge.
    wait_writes(474, 20);
    chk("pre_reset_p5", fifo_din, 32'h5);
    cfg_byte = 8'hC0;
    tick();
    chk("reset_idle",  32'(daq_running), 32'd0);
    chk("reset_wr_en", 32'(fifo_wr_en),  32'd0);
    chk("reset_din",   fifo_din,         32'h0);
    chk("reset_line",  32'(line_idx),    32'd0);
    cfg_byte = 8'h00;
    tick();
    chk("reset_00_idle", 32'(daq_running), 32'd0);
    cfg_byte = 8'hFF;
    tick();
    chk("rerun_running", 32'(daq_running), 32'd1);
    chk("rerun_hdr",     fifo_din,         32'hF000_0000);
    tick();
    chk("rerun_p0", fifo_din, 32'h0);

    // fifo_open drops mid-line.
    tick();
    tick();
    fifo_open = 1'b0;
    tick();
    chk("drop_idle",  32'(daq_running), 32'd0);
    chk("drop_wr_en", 32'(fifo_wr_en),  32'd0);
    cfg_byte = 8'h00;
    tick();
    cfg_byte = 8'hFF;
    tick();
    chk("closed_start_ignored", 32'(daq_running), 32'd0);
    fifo_open = 1'b1;
    tick();
    tick();
    tick();
    chk("static_ff_no_restart", 32'(daq_running), 32'd0);
    cfg_byte = 8'h00;
    tick();
    cfg_byte = 8'hFF;
    tick();
    chk("reopen_running", 32'(daq_running), 32'd1);
    chk("reopen_hdr",     fifo_din,         32'hF000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/daq_frame_ctrl.md
Name: daq_frame_ctrl

Overview:
- Sequences DAQ test-data acquisition into the 32-bit FPGA-to-host FIFO (fifo_32x512 feeding /dev/xillybus_read_32).
- Decodes command bytes that the host writes to address 0 of the mem_8 register array: start, reset, close.
- Emits framed lines: header word, payload words, tailer word.
- Stalls on FIFO full; aborts when the host closes the read device.

Parameters:
- WORDS_PER_LINE, 24, payload words per line (768 bits / 32); legal range 1..255.
- LINES_PER_FRAME, 16, lines per frame before line index wraps; legal range 1..65535.
- CMD_START, 8'hFF, start command code.
- CMD_RESET, 8'hC0, reset command code.
- CMD_CLOSE, 8'hC7, close command code.

Ports:
- bus_clk  in  1  Xillybus bus clock; all logic on rising edge.
- bus_rst_n  in  1  synchronous active-low reset.
- cfg_byte  in  8  demoarray[0] contents (level).
- fifo_open  in  1  user_r_read_32_open.
- fifo_full  in  1  FIFO full flag.
- fifo_din  out  32  FIFO write data (combinational from state/counters).
- fifo_wr_en  out  1  FIFO write strobe (combinational).
- daq_running  out  1  high in any emitting state.
- frame_done  out  1  one-cycle pulse after the last tailer of a frame is written.
- line_idx  out  16  current line within frame.
- frame_cnt  out  16  completed frames since start; wraps at 2^16.

Behaviour:
- Reset (bus_rst_n=0 at an edge):
  - state=IDLE; cfg_q=cfg_byte; all counters 0.
  - frame_done=0; fifo_wr_en=0; daq_running=0.
  - fifo_din=0 while in IDLE.
- Command detect:
  - cfg_q registers cfg_byte every cycle.
  - A command is valid only on change: cfg_byte != cfg_q and cfg_byte equals a code.
  - A static value re-triggers nothing; the host must write another value first to repeat a command.
  - Unknown codes are ignored.
- States: IDLE, HDR, PAY, TAIL, ABORT-free (reset acts directly).
- IDLE, START valid and fifo_open=1:
  - go to HDR.
  - clear payload counter, line_idx, frame_cnt, word index.
  - START while fifo_open=0 is ignored.
- HDR: fifo_din = {8'hF0, 8'h00, line_idx}. On accepted write, go to PAY with word index 0.
- PAY:
  - fifo_din = payload counter (32-bit, +1 per accepted payload word, wraps).
  - After WORDS_PER_LINE accepted words, go to TAIL.
- TAIL:
  - fifo_din = {8'hAA, tail_low24}.
  - On accepted write:
    - if line_idx == LINES_PER_FRAME-1: line_idx=0, frame_cnt+1, frame_done pulses next cycle.
    - else line_idx+1.
  - Next state: HDR, or IDLE if a close is pending.
- Accepted write: fifo_wr_en = (state in HDR/PAY/TAIL) && !fifo_full. While fifo_full=1, state, counters and fifo_din hold.
- CLOSE valid while running: set close_pending. The current line completes through TAIL, then IDLE. CLOSE in IDLE is a no-op.
- RESET valid in any state:
  - next edge: IDLE, all counters 0, close_pending cleared.
  - a partial line is abandoned.
- fifo_open falling while running: same effect as RESET (the FIFO is reset by the top level).
- Priority at one edge: bus_rst_n > RESET/fifo_open drop > CLOSE > normal advance.
- Latency: cfg_byte becomes 8'hFF before edge k → state HDR after k → header write in the cycle after k.
- daq_running = state != IDLE; it drives GPIO_LED_6.
- Line length: 26 words at default parameters; no idle cycles between words when not full.

Optional Feature:
- DAQ_CHECKSUM_EN defined:
  - tail_low24 = XOR of bits [23:0] of all payload words of the line.
  - The accumulator clears on entry to HDR.
- DAQ_CHECKSUM_EN not defined:
  - tail_low24 = {8'h00, line_idx}.
  - No accumulator is synthesized.

Test Plan:
- Reset, then cfg_byte 00→FF, fifo_open=1, fifo_full=0:
  - writes in order: F0000000, then 00000000..00000017, then tailer.
  - tailer is AA000000 without the feature; AA000000 XOR-fold value with it.
  - second line header is F0000001.
- Run 16 lines continuously:
  - frame_done pulses once, 1 cycle after the 416th write.
  - frame_cnt=1; next header is F0000000; payload continues at 0x00000180.
- Hold fifo_full=1 for 10 cycles mid-PAY:
  - fifo_wr_en=0 throughout.
  - fifo_din is frozen on the same value.
  - after release, the sequence continues with no gap or duplicate.
- cfg_byte FF→C7 at payload word 5:
  - line completes through TAIL, then IDLE, daq_running=0.
  - cfg_byte →FF again restarts at header F0000000, payload 0.
- cfg_byte FF→C0 at payload word 5 → next cycle IDLE, fifo_wr_en=0; a following 00→FF restarts at line 0, payload 0.
- Drop fifo_open mid-line → IDLE next cycle; FF held constant after reopen → no restart until the value changes.
